fuvrf_config_writer: RTL and testbench
======================================

Name: fuvrf_config_writer

Overview:
- Write side of the filter-unit vector register file (FUVRF) dual-port RAM; the filter reduce unit reads filter operands on port A, this block drives port B.
- Assembles M*DATA_WIDTH-bit operand words from the byte-serial configuration bus (configId/configData).
- Commits each word to the addressed FUVRF entry, only while tracing is low, so a running trace never sees a read-during-write.

Parameters:
- M, 8, vector elements per FUVRF word.
- DATA_WIDTH, 32, bits per element; must be a multiple of 8.
- FUVRF_SIZE, 4, FUVRF entries; power of two, at most 256.
- PERSONAL_CONFIG_ID, 1, configId value addressed to this block.
- Derived BYTES_PER_WORD = M*DATA_WIDTH/8.
- Derived MEM_WIDTH = M*DATA_WIDTH.
- Derived AW = $clog2(FUVRF_SIZE).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- tracing  in  1  trace active; blocks commits
- configValid  in  1  configuration byte strobe
- configId  in  8  target block id
- configData  in  8  configuration byte
- errClear  in  1  synchronous clear of error
- mem_address_b  out  AW  FUVRF port-B address
- mem_in_b  out  MEM_WIDTH  FUVRF port-B write data
- mem_write_enable_b  out  1  FUVRF port-B write strobe, one cycle per commit
- busy  out  1  frame in progress or commit pending
- error  out  1  sticky error flag
- words_written  out  16  count of committed words, wraps

Behaviour:
- Byte accepted on a rising edge when configValid=1 and configId==PERSONAL_CONFIG_ID. All other cycles are ignored.
- Frame format: 1 address byte, then BYTES_PER_WORD data bytes.
- Data is little-endian: data byte j lands in mem_in_b[8j+7:8j], so element 0 is byte 0..3 for DATA_WIDTH=32.
- State IDLE (busy=0):
  - Accepted byte is the address; go to LOAD and clear the byte counter.
  - If address byte >= FUVRF_SIZE: set error, set internal discard flag.
- State LOAD (busy=1):
  - Each accepted byte shifts into the assembly register; the counter increments.
  - On the BYTES_PER_WORD-th byte with discard=1: go to IDLE, no write.
  - Otherwise, if tracing=0 on that same edge: go to COMMIT. If tracing=1: go to PENDING.
- State PENDING (busy=1):
  - Hold the assembled word.
  - On the first edge sampling tracing=0, go to COMMIT.
  - Any byte accepted while in PENDING is dropped and sets error.
- State COMMIT (busy=1), lasts exactly one cycle:
  - mem_write_enable_b=1, with mem_address_b/mem_in_b stable at the frame values.
  - words_written increments at the end of the cycle.
  - Next state IDLE.
  - A byte accepted during COMMIT is dropped and sets error; a new frame may start from the next cycle.
- Write-enable latency: mem_write_enable_b is registered. It is high in the cycle after the edge that sampled the last data byte, given tracing=0.
- mem_address_b and mem_in_b:
  - Change only at frame start (address) or on data bytes.
  - Hold their last values otherwise.
  - No requirement on their value while mem_write_enable_b=0.
- error:
  - Sticky; cleared by errClear.
  - A set event in the same cycle as errClear wins (error stays 1).
- Reset is asynchronous:
  - State IDLE, mem_write_enable_b=0, mem_address_b=0, mem_in_b=0, busy=0, error=0, words_written=0, counter=0, discard=0.
  - Reset mid-frame or mid-PENDING abandons the word; no write is issued.
- words_written wraps 0xFFFF -> 0x0000.

Decomposition:
- Shared package fuvrf_cfg_pkg holds:
  - state enum (IDLE, LOAD, PENDING, COMMIT),
  - BYTES_PER_WORD/MEM_WIDTH helper functions,
  - config-id constants for all blocks on the config bus.
- No sub-module: FSM, counter and shift register sit in one module.

Test Plan:
- Bench parameters: M=2, DATA_WIDTH=32, FUVRF_SIZE=4, PERSONAL_CONFIG_ID=1, so 8 data bytes per frame.
- Basic write, tracing=0: bytes 0x02, 0x11..0x18 → one-cycle mem_write_enable_b the cycle after byte 0x18; mem_address_b=2, mem_in_b=0x1817161514131211; words_written=1, busy back to 0.
- Tracing defer: same frame with tracing=1 held for 5 cycles after the last byte → no write during those 5 cycles; write pulse the cycle after tracing drops; exactly one pulse.
- Foreign id and gaps: bytes interleaved with configId=3 and configValid=0 idle cycles → ignored; data and address identical to the basic write.
- Bad address: address byte 0x07 then 8 data bytes → error=1, no write pulse, state IDLE. A following valid frame to address 1 writes normally; errClear then drops error to 0.
- Overrun: byte sent while in PENDING → error=1, held word unchanged and committed when tracing drops.
- Async reset asserted after 4 data bytes → outputs zero immediately with no clock edge; fresh frame after release writes correctly; no stale bytes.

Source files
------------

// File: rtl/fuvrf_cfg_pkg.sv
// ---------------------------------------------------------------------------
// fuvrf_cfg_pkg
// Shared definitions for blocks that sit on the byte-serial configuration bus
// and for the FUVRF write side:
//   - fuvrf_state_t   : states of the config-writer FSM
//   - bytes_per_word  : bytes in one M x DATA_WIDTH FUVRF word
//   - mem_width       : bit width of one FUVRF word
//   - CFG_ID_*        : configId values of every block on the config bus
// ---------------------------------------------------------------------------
package fuvrf_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_PENDING = 2'd2,
        ST_COMMIT  = 2'd3
    } fuvrf_state_t;

    // Config-bus block ids.
    localparam logic [7:0] CFG_ID_TRACE_CTRL   = 8'd0;
    localparam logic [7:0] CFG_ID_FUVRF        = 8'd1;
    localparam logic [7:0] CFG_ID_FILTER_RED   = 8'd2;
    localparam logic [7:0] CFG_ID_TRIGGER      = 8'd3;

    function automatic int bytes_per_word(input int m, input int data_width);
        return (m * data_width) / 8;
    endfunction

    function automatic int mem_width(input int m, input int data_width);
        return m * data_width;
    endfunction

endpackage

// File: rtl/fuvrf_config_writer.sv
// ---------------------------------------------------------------------------
// fuvrf_config_writer
// Write side (port B) of the FUVRF dual-port RAM. Assembles one FUVRF word
// from a config-bus frame (1 address byte + BYTES_PER_WORD data bytes,
// little-endian) and commits it with a one-cycle write strobe, but only while
// tracing is low so a running trace never sees a read-during-write.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   tracing             trace active; holds a finished word in PENDING
//   configValid/Id/Data byte-serial configuration bus
//   errClear            synchronous clear of the sticky error flag
//   mem_address_b       FUVRF port-B address
//   mem_in_b            FUVRF port-B write data
//   mem_write_enable_b  FUVRF port-B write strobe, one cycle per commit
//   busy                frame in progress or commit pending
//   error               sticky: bad address or byte dropped in PENDING/COMMIT
//   words_written       count of committed words, wraps at 16 bits
// ---------------------------------------------------------------------------
module fuvrf_config_writer
    import fuvrf_cfg_pkg::*;
#(
    parameter int         M                  = 8,
    parameter int         DATA_WIDTH         = 32,
    parameter int         FUVRF_SIZE         = 4,
    parameter logic [7:0] PERSONAL_CONFIG_ID = CFG_ID_FUVRF,
    localparam int        BYTES_PER_WORD     = bytes_per_word(M, DATA_WIDTH),
    localparam int        MEM_WIDTH          = mem_width(M, DATA_WIDTH),
    localparam int        AW                 = (FUVRF_SIZE > 1) ? $clog2(FUVRF_SIZE) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tracing,
    input  logic                 configValid,
    input  logic [7:0]           configId,
    input  logic [7:0]           configData,
    input  logic                 errClear,
    output logic [AW-1:0]        mem_address_b,
    output logic [MEM_WIDTH-1:0] mem_in_b,
    output logic                 mem_write_enable_b,
    output logic                 busy,
    output logic                 error,
    output logic [15:0]          words_written
);

    localparam int CW = $clog2(BYTES_PER_WORD + 1);

    fuvrf_state_t         state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 discard_q, discard_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [MEM_WIDTH-1:0] data_q, data_d;
    logic                 we_q, we_d;
    logic                 err_q, err_d;
    logic [15:0]          ww_q, ww_d;

    logic accept;
    logic last_byte;
    logic addr_bad;
    logic err_set;

    assign accept    = configValid && (configId == PERSONAL_CONFIG_ID);
    assign last_byte = accept && (cnt_q == CW'(BYTES_PER_WORD - 1));
    assign addr_bad  = (int'(configData) >= FUVRF_SIZE);

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            discard_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            ww_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            discard_q <= discard_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            err_q     <= err_d;
            ww_q      <= ww_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (last_byte) begin
                    if (discard_q)    state_d = ST_IDLE;
                    else if (tracing) state_d = ST_PENDING;
                    else              state_d = ST_COMMIT;
                end
            end
            ST_PENDING: begin
                if (!tracing) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: counter, assembly shift register, error, count.
    always_comb begin
        cnt_d     = cnt_q;
        discard_d = discard_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err_set   = 1'b0;
        ww_d      = ww_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d     = '0;
                    discard_d = addr_bad;
                    addr_d    = configData[AW-1:0];
                    err_set   = addr_bad;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    // Shift right so the first data byte ends in bits [7:0].
                    data_d = {configData, data_q[MEM_WIDTH-1:8]};
                    cnt_d  = cnt_q + CW'(1);
                end
            end
            ST_PENDING: begin
                if (accept) err_set = 1'b1;
            end
            ST_COMMIT: begin
                if (accept) err_set = 1'b1;
                ww_d = ww_q + 16'd1;
            end
            default: ;
        endcase

        // A set event in the same cycle as errClear keeps the flag high.
        err_d = err_set | (err_q & ~errClear);
        we_d  = (state_d == ST_COMMIT);
    end

    // Outputs.
    always_comb begin
        mem_write_enable_b = we_q;
        busy               = (state_q != ST_IDLE);
        mem_address_b      = addr_q;
        mem_in_b           = data_q;
        error              = err_q;
        words_written      = ww_q;
    end

endmodule

// File: tb/tb_fuvrf_config_writer.sv
// ---------------------------------------------------------------------------
// tb_fuvrf_config_writer
// Scoreboard bench for fuvrf_config_writer (M=2, DATA_WIDTH=32, FUVRF_SIZE=4,
// PERSONAL_CONFIG_ID=1). Stimulus pushes the hand-computed expected write into
// a queue; a negedge monitor pops and compares on every write strobe.
// ---------------------------------------------------------------------------
module tb_fuvrf_config_writer;

    localparam logic [7:0] ID = 8'd1;

    logic        clk = 1'b0;
    logic        reset;
    logic        tracing;
    logic        configValid;
    logic [7:0]  configId;
    logic [7:0]  configData;
    logic        errClear;
    logic [1:0]  mem_address_b;
    logic [63:0] mem_in_b;
    logic        mem_write_enable_b;
    logic        busy;
    logic        error;
    logic [15:0] words_written;

    typedef struct packed {
        logic [1:0]  a;
        logic [63:0] d;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;
    int   p0;

    fuvrf_config_writer #(
        .M(2), .DATA_WIDTH(32), .FUVRF_SIZE(4), .PERSONAL_CONFIG_ID(ID)
    ) dut (
        .clk(clk), .reset(reset), .tracing(tracing),
        .configValid(configValid), .configId(configId), .configData(configData),
        .errClear(errClear),
        .mem_address_b(mem_address_b), .mem_in_b(mem_in_b),
        .mem_write_enable_b(mem_write_enable_b),
        .busy(busy), .error(error), .words_written(words_written)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && mem_write_enable_b) begin
            pulses++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         mem_address_b, mem_in_b);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 64'(mem_address_b), 64'(e.a));
                chk("wr_data", mem_in_b, e.d);
            end
        end
    end

    // One bus cycle; the byte is sampled on the posedge inside this task.
    task automatic cyc(input logic v, input logic [7:0] id, input logic [7:0] d);
        configValid = v;
        configId    = id;
        configData  = d;
        @(negedge clk);
        configValid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] a, input logic [7:0] base);
        cyc(1'b1, ID, a);
        for (int j = 0; j < 8; j++) cyc(1'b1, ID, base + 8'(j));
    endtask

    initial begin
        reset = 1'b1; tracing = 1'b0; configValid = 1'b0;
        configId = 8'd0; configData = 8'd0; errClear = 1'b0;
        @(negedge clk);
        chk("rst_we",   64'(mem_write_enable_b), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err",  64'(error), 64'd0);
        chk("rst_ww",   64'(words_written), 64'd0);
        chk("rst_data", mem_in_b, 64'd0);
        reset = 1'b0;
        cyc(1'b0, 8'd0, 8'd0);

        // Basic write.
        sb.push_back('{a: 2'd2, d: 64'h1817161514131211});
        cyc(1'b1, ID, 8'h02);
        chk("basic_busy", 64'(busy), 64'd1);
        frame_data_only(8'h11);
        chk("basic_we", 64'(mem_write_enable_b), 64'd1);
        cyc(1'b0, 8'd0, 8'd0);
        chk("basic_we_off", 64'(mem_write_enable_b), 64'd0);
        chk("basic_ww",     64'(words_written), 64'd1);
        chk("basic_idle",   64'(busy), 64'd0);

        // Tracing defers the commit.
        tracing = 1'b1;
        p0 = pulses;
        sb.push_back('{a: 2'd2, d: 64'h1817161514131211});
        frame(8'h02, 8'h11);
        for (int k = 0; k < 5; k++) begin
            chk("defer_no_we", 64'(mem_write_enable_b), 64'd0);
            chk("defer_busy",  64'(busy), 64'd1);
            cyc(1'b0, 8'd0, 8'd0);
        end
        tracing = 1'b0;
        cyc(1'b0, 8'd0, 8'd0);
        chk("defer_we", 64'(mem_write_enable_b), 64'd1);
        cyc(1'b0, 8'd0, 8'd0);
        #1;
        chk("defer_one_pulse", 64'(pulses - p0), 64'd1);
        chk("defer_ww", 64'(words_written), 64'd2);

        // Foreign ids and idle gaps are ignored.
        sb.push_back('{a: 2'd2, d: 64'h1817161514131211});
        cyc(1'b1, ID, 8'h02);
        for (int j = 0; j < 8; j++) begin
            cyc(1'b1, 8'd3, 8'hEE);
            cyc(1'b0, ID, 8'h55);
            cyc(1'b1, ID, 8'h11 + 8'(j));
        end
        chk("foreign_we", 64'(mem_write_enable_b), 64'd1);
        cyc(1'b0, 8'd0, 8'd0);
        chk("foreign_ww", 64'(words_written), 64'd3);

        // Bad address: error, no write, back to idle.
        cyc(1'b1, ID, 8'h07);
        chk("bad_err",  64'(error), 64'd1);
        chk("bad_busy", 64'(busy), 64'd1);
        frame_data_only(8'h61);
        chk("bad_idle",  64'(busy), 64'd0);
        chk("bad_no_we", 64'(mem_write_enable_b), 64'd0);
        cyc(1'b0, 8'd0, 8'd0);
        sb.push_back('{a: 2'd1, d: 64'h2827262524232221});
        frame(8'h01, 8'h21);
        chk("after_bad_we", 64'(mem_write_enable_b), 64'd1);
        cyc(1'b0, 8'd0, 8'd0);
        chk("after_bad_ww",  64'(words_written), 64'd4);
        chk("err_sticky",    64'(error), 64'd1);
        // errClear together with a new set event keeps error high.
        errClear = 1'b1;
        cyc(1'b1, ID, 8'h09);
        errClear = 1'b0;
        chk("set_wins", 64'(error), 64'd1);
        frame_data_only(8'h71);
        errClear = 1'b1;
        cyc(1'b0, 8'd0, 8'd0);
        errClear = 1'b0;
        chk("err_cleared", 64'(error), 64'd0);

        // Overrun while pending: byte dropped, held word committed later.
        tracing = 1'b1;
        sb.push_back('{a: 2'd3, d: 64'h3837363534333231});
        frame(8'h03, 8'h31);
        chk("ovr_busy", 64'(busy), 64'd1);
        cyc(1'b1, ID, 8'hAA);
        chk("ovr_err",   64'(error), 64'd1);
        chk("ovr_held",  mem_in_b, 64'h3837363534333231);
        tracing = 1'b0;
        cyc(1'b0, 8'd0, 8'd0);
        chk("ovr_we", 64'(mem_write_enable_b), 64'd1);
        cyc(1'b0, 8'd0, 8'd0);
        chk("ovr_ww", 64'(words_written), 64'd5);

        // Asynchronous reset mid-frame.
        cyc(1'b1, ID, 8'h00);
        for (int j = 0; j < 4; j++) cyc(1'b1, ID, 8'h41 + 8'(j));
        #2 reset = 1'b1;
        #1;
        chk("arst_data", mem_in_b, 64'd0);
        chk("arst_addr", 64'(mem_address_b), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_we",   64'(mem_write_enable_b), 64'd0);
        chk("arst_ww",   64'(words_written), 64'd0);
        chk("arst_err",  64'(error), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        p0 = pulses;
        sb.push_back('{a: 2'd1, d: 64'h5857565554535251});
        frame(8'h01, 8'h51);
        chk("fresh_we", 64'(mem_write_enable_b), 64'd1);
        cyc(1'b0, 8'd0, 8'd0);
        #1;
        chk("fresh_one_pulse", 64'(pulses - p0), 64'd1);
        chk("fresh_ww",        64'(words_written), 64'd1);
        chk("sb_drained",      64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    task automatic frame_data_only(input logic [7:0] base);
        for (int j = 0; j < 8; j++) cyc(1'b1, ID, base + 8'(j));
    endtask

endmodule
